// File: rtl/m_ctx_stacker.sv
// Context save/restore sequencer: pushes NREG register-file words onto an external
// LIFO on save and pops them back into their slots on restore. Optional: CTX_CHECKSUM_EN.
module m_ctx_stacker #(
  parameter int WORD = 16,
  parameter int NREG = 8,
  localparam int IW = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            save_req,
  input  logic            restore_req,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic            stk_push,
  output logic            stk_pop,
  output logic [WORD-1:0] stk_wdata,
  input  logic [WORD-1:0] stk_rdata,
  input  logic            stk_full,
  input  logic            stk_empty,
  output logic [IW-1:0]   rf_raddr,
  input  logic [WORD-1:0] rf_rdata,
  output logic            rf_we,
  output logic [IW-1:0]   rf_waddr,
  output logic [WORD-1:0] rf_wdata
);

  typedef enum logic [2:0] {IDLE, SAVE, POP, WB, DONE} state_t;

  localparam logic [IW-1:0] LAST = IW'(NREG - 1);

  state_t        state, state_nx;
  logic [IW-1:0] idx, idx_nx;
  logic          err_nx;

`ifdef CTX_CHECKSUM_EN
  // ck_phase marks the extra checksum beat: last push on save, first pop on restore
  logic            ck_phase, ck_phase_nx;
  logic [WORD-1:0] ck_acc, ck_acc_nx;
  logic [WORD-1:0] ck_ref, ck_ref_nx;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      idx      <= '0;
      err      <= 1'b0;
`ifdef CTX_CHECKSUM_EN
      ck_phase <= 1'b0;
      ck_acc   <= '0;
      ck_ref   <= '0;
`endif
    end else begin
      state    <= state_nx;
      idx      <= idx_nx;
      err      <= err_nx;
`ifdef CTX_CHECKSUM_EN
      ck_phase <= ck_phase_nx;
      ck_acc   <= ck_acc_nx;
      ck_ref   <= ck_ref_nx;
`endif
    end
  end

  always_comb begin
    state_nx    = state;
    idx_nx      = idx;
    err_nx      = err;
    busy        = (state != IDLE);
    done        = 1'b0;
    stk_push    = 1'b0;
    stk_pop     = 1'b0;
    stk_wdata   = '0;
    rf_raddr    = '0;
    rf_we       = 1'b0;
    rf_waddr    = '0;
    rf_wdata    = '0;
`ifdef CTX_CHECKSUM_EN
    ck_phase_nx = ck_phase;
    ck_acc_nx   = ck_acc;
    ck_ref_nx   = ck_ref;
`endif

    case (state)
      IDLE: begin
        if (save_req) begin
          state_nx    = SAVE;
          idx_nx      = '0;
          err_nx      = 1'b0;
`ifdef CTX_CHECKSUM_EN
          ck_phase_nx = 1'b0;
          ck_acc_nx   = '0;
`endif
        end else if (restore_req) begin
          state_nx    = POP;
          idx_nx      = LAST;
          err_nx      = 1'b0;
`ifdef CTX_CHECKSUM_EN
          ck_phase_nx = 1'b1;
          ck_acc_nx   = '0;
`endif
        end
      end

      SAVE: begin
        stk_push  = !stk_full;
`ifdef CTX_CHECKSUM_EN
        if (ck_phase) begin
          stk_wdata = ck_acc;
        end else begin
          rf_raddr  = idx;
          stk_wdata = rf_rdata;
        end
        if (stk_full) begin
          err_nx   = 1'b1;
          state_nx = DONE;
        end else if (ck_phase) begin
          ck_phase_nx = 1'b0;
          state_nx    = DONE;
        end else begin
          ck_acc_nx = ck_acc ^ rf_rdata;
          if (idx == LAST) ck_phase_nx = 1'b1;
          else             idx_nx      = idx + IW'(1);
        end
`else
        rf_raddr  = idx;
        stk_wdata = rf_rdata;
        if (stk_full) begin
          err_nx   = 1'b1;
          state_nx = DONE;
        end else if (idx == LAST) begin
          state_nx = DONE;
        end else begin
          idx_nx = idx + IW'(1);
        end
`endif
      end

      POP: begin
        if (stk_empty) begin
          err_nx   = 1'b1;
          state_nx = DONE;
        end else begin
          stk_pop  = 1'b1;
          state_nx = WB;
        end
      end

      WB: begin
`ifdef CTX_CHECKSUM_EN
        if (ck_phase) begin
          ck_ref_nx   = stk_rdata;
          ck_phase_nx = 1'b0;
          state_nx    = POP;
        end else begin
          rf_we     = 1'b1;
          rf_waddr  = idx;
          rf_wdata  = stk_rdata;
          ck_acc_nx = ck_acc ^ stk_rdata;
          if (idx == '0) begin
            if (ck_acc_nx != ck_ref) err_nx = 1'b1;
            state_nx = DONE;
          end else begin
            idx_nx   = idx - IW'(1);
            state_nx = POP;
          end
        end
`else
        rf_we    = 1'b1;
        rf_waddr = idx;
        rf_wdata = stk_rdata;
        if (idx == '0) begin
          state_nx = DONE;
        end else begin
          idx_nx   = idx - IW'(1);
          state_nx = POP;
        end
`endif
      end

      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end

      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_m_ctx_stacker.sv
// Self-checking bench for m_ctx_stacker: transaction-level model predicts every
// output cycle; environment provides a LIFO stack and a register file.
module tb_m_ctx_stacker;

  localparam int WORD  = 16;
  localparam int NREG  = 8;
  localparam int IW    = 3;
  localparam int DEPTH = 32;
`ifdef CTX_CHECKSUM_EN
  localparam int CK_EN = 1;
`else
  localparam int CK_EN = 0;
`endif

  typedef struct packed {
    logic            busy;
    logic            done;
    logic            err;
    logic            push;
    logic            pop;
    logic            we;
    logic [IW-1:0]   raddr;
    logic [IW-1:0]   waddr;
    logic [WORD-1:0] swdata;
    logic [WORD-1:0] rwdata;
  } obs_t;

  logic            clk;
  logic            reset;
  logic            save_req;
  logic            restore_req;
  logic            busy;
  logic            done;
  logic            err;
  logic            stk_push;
  logic            stk_pop;
  logic [WORD-1:0] stk_wdata;
  logic [WORD-1:0] stk_rdata = '0;
  logic            stk_full;
  logic            stk_empty;
  logic [IW-1:0]   rf_raddr;
  logic [WORD-1:0] rf_rdata;
  logic            rf_we;
  logic [IW-1:0]   rf_waddr;
  logic [WORD-1:0] rf_wdata;

  m_ctx_stacker #(.WORD(WORD), .NREG(NREG)) dut (
    .clk(clk), .reset(reset), .save_req(save_req), .restore_req(restore_req),
    .busy(busy), .done(done), .err(err), .stk_push(stk_push), .stk_pop(stk_pop),
    .stk_wdata(stk_wdata), .stk_rdata(stk_rdata), .stk_full(stk_full),
    .stk_empty(stk_empty), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Environment: LIFO stack with registered pop data, and a register file
  logic [WORD-1:0] mem [DEPTH];
  int              sp = 0;
  int              cap = DEPTH;
  logic            stk_clear = 1'b0;
  logic            stk_corrupt = 1'b0;
  logic [WORD-1:0] rf [NREG];
  logic [WORD-1:0] rf_init [NREG];
  logic            rf_load = 1'b0;

  assign stk_full  = (sp >= cap);
  assign stk_empty = (sp == 0);
  assign rf_rdata  = rf[rf_raddr];

  always @(posedge clk) begin
    if (stk_clear) begin
      sp <= 0;
    end else begin
      if (stk_corrupt && sp != 0) mem[sp-1] <= mem[sp-1] ^ 16'h0001;
      if (stk_push && sp < DEPTH) begin
        mem[sp] <= stk_wdata;
        sp      <= sp + 1;
      end else if (stk_pop && sp != 0) begin
        stk_rdata <= mem[sp-1];
        sp        <= sp - 1;
      end
    end
  end

  always @(posedge clk) begin
    if (rf_load) rf <= rf_init;
    else if (rf_we) rf[rf_waddr] <= rf_wdata;
  end

  // Reference model state
  obs_t            exp_q [$];
  logic [WORD-1:0] mstk [$];
  logic            model_err = 1'b0;
  logic            chk_en = 1'b0;
  int              n_checks = 0;
  int              n_errors = 0;

  obs_t act;
  assign act = {busy, done, err, stk_push, stk_pop, rf_we, rf_raddr, rf_waddr, stk_wdata, rf_wdata};

  function automatic obs_t mk(input logic b, input logic dn, input logic e, input logic pu,
                              input logic po, input logic we, input logic [IW-1:0] ra,
                              input logic [IW-1:0] wa, input logic [WORD-1:0] sw,
                              input logic [WORD-1:0] rw);
    return {b, dn, e, pu, po, we, ra, wa, sw, rw};
  endfunction

  task automatic check_output(input string name, input obs_t a, input obs_t e);
    n_checks++;
    if (a !== e) begin
      n_errors++;
      $display("[TB] FAIL %s @%0t: got %h expected %h", name, $time, a, e);
    end
  endtask

  task automatic check_val(input string name, input logic [63:0] a, input logic [63:0] e);
    n_checks++;
    if (a !== e) begin
      n_errors++;
      $display("[TB] FAIL %s @%0t: got %0h expected %0h", name, $time, a, e);
    end
  endtask

  always @(negedge clk) begin
    obs_t e;
    if (chk_en && !reset) begin
      if (exp_q.size() != 0) e = exp_q.pop_front();
      else e = mk(1'b0, 1'b0, model_err, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
      check_output("cycle", act, e);
    end
  end

  // Expected trace for a save: request cycle, one beat per word, then DONE
  task automatic build_save();
    int              free;
    logic [WORD-1:0] x;
    logic [WORD-1:0] d;
    logic [IW-1:0]   ra;
    logic            failed;
    free   = cap - mstk.size();
    x      = '0;
    failed = 1'b0;
    exp_q.push_back(mk(1'b0, 1'b0, model_err, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0));
    for (int i = 0; i < NREG + CK_EN; i++) begin
      d  = (i < NREG) ? rf_init[i] : x;
      ra = (i < NREG) ? IW'(i) : '0;
      if (i < free) begin
        exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, ra, '0, d, '0));
        mstk.push_back(d);
        x = x ^ d;
      end else begin
        exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ra, '0, d, '0));
        failed = 1'b1;
        break;
      end
    end
    exp_q.push_back(mk(1'b1, 1'b1, failed, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0));
    model_err = failed;
  endtask

  // Expected trace for a restore: POP/WB pairs walking slots downward, then DONE
  task automatic build_restore();
    logic [WORD-1:0] x;
    logic [WORD-1:0] ck;
    logic [WORD-1:0] d;
    logic            failed;
    x      = '0;
    ck     = '0;
    failed = 1'b0;
    exp_q.push_back(mk(1'b0, 1'b0, model_err, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0));
    for (int k = 0; k < NREG + CK_EN; k++) begin
      if (mstk.size() == 0) begin
        exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0));
        failed = 1'b1;
        break;
      end
      exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0, '0, '0, '0));
      d = mstk.pop_back();
      if (CK_EN == 1 && k == 0) begin
        ck = d;
        exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0));
      end else begin
        exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0, IW'(NREG - 1 - (k - CK_EN)), '0, d));
        x = x ^ d;
      end
    end
    if (!failed && CK_EN == 1 && x != ck) failed = 1'b1;
    exp_q.push_back(mk(1'b1, 1'b1, failed, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0));
    model_err = failed;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_rf();
    rf_load = 1'b1;
    tick();
    rf_load = 1'b0;
  endtask

  task automatic clear_stack();
    stk_clear = 1'b1;
    tick();
    stk_clear = 1'b0;
    mstk.delete();
  endtask

  task automatic apply_stimulus(input bit is_save, input bit both);
    if (is_save || both) build_save();
    else build_restore();
    save_req    = is_save | both;
    restore_req = !is_save | both;
    tick();
    save_req    = 1'b0;
    restore_req = 1'b0;
  endtask

  task automatic finish_op();
    int budget;
    budget = 200;
    while (exp_q.size() != 0 && budget > 0) begin
      tick();
      budget--;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("[TB] FAIL op_timeout: %0d cycles left, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset       = 1'b1;
    save_req    = 1'b0;
    restore_req = 1'b0;
    repeat (2) tick();
    check_val("reset_outputs", 64'(act), 64'h0);
    reset = 1'b0;
    tick();
    chk_en = 1'b1;

    // Save a known context
    for (int i = 0; i < NREG; i++) rf_init[i] = WORD'(16'h1000 + i);
    load_rf();
    apply_stimulus(1'b1, 1'b0);
    finish_op();
    check_val("save_depth", 64'(sp), 64'(NREG + CK_EN));
    check_val("save_first", 64'(mem[0]), 64'h1000);
    check_val("save_last", 64'(mem[7]), 64'h1007);
    check_val("save_err", 64'(err), 64'h0);

    // Clobber and restore
    for (int i = 0; i < NREG; i++) rf_init[i] = '0;
    load_rf();
    apply_stimulus(1'b0, 1'b0);
    finish_op();
    for (int i = 0; i < NREG; i++) check_val("restore_rf", 64'(rf[i]), 64'(16'h1000 + i));
    check_val("restore_depth", 64'(sp), 64'h0);
    check_val("restore_err", 64'(err), 64'h0);

    // Stack with three free entries
    for (int i = 0; i < NREG; i++) rf_init[i] = WORD'(16'h2000 + i);
    load_rf();
    cap = 3;
    apply_stimulus(1'b1, 1'b0);
    finish_op();
    check_val("full_pushes", 64'(sp), 64'h3);
    check_val("full_err", 64'(err), 64'h1);
    cap = DEPTH;
    apply_stimulus(1'b1, 1'b0);
    finish_op();
    check_val("err_cleared", 64'(err), 64'h0);
    clear_stack();

    // Restore from empty stack
    apply_stimulus(1'b0, 1'b0);
    finish_op();
    check_val("empty_err", 64'(err), 64'h1);

    // Simultaneous requests: save wins
    apply_stimulus(1'b0, 1'b1);
    finish_op();
    check_val("both_depth", 64'(sp), 64'(NREG + CK_EN));
    clear_stack();

    // Reset during the fourth push
    apply_stimulus(1'b1, 1'b0);
    repeat (3) tick();
    chk_en = 1'b0;
    reset  = 1'b1;
    #1;
    check_val("midreset_outputs", 64'(act), 64'h0);
    tick();
    check_val("midreset_pushes", 64'(sp), 64'h3);
    reset = 1'b0;
    exp_q.delete();
    model_err = 1'b0;
    clear_stack();
    chk_en = 1'b1;

`ifdef CTX_CHECKSUM_EN
    // Corrupted checksum entry must flag an error after restore
    for (int i = 0; i < NREG; i++) rf_init[i] = WORD'(16'h3000 + 3 * i);
    load_rf();
    apply_stimulus(1'b1, 1'b0);
    finish_op();
    stk_corrupt = 1'b1;
    tick();
    stk_corrupt = 1'b0;
    mstk[$] = mstk[$] ^ 16'h0001;
    apply_stimulus(1'b0, 1'b0);
    finish_op();
    check_val("ck_corrupt_err", 64'(err), 64'h1);
    clear_stack();
`endif

    // Randomized operations against the model
    for (int n = 0; n < 40; n++) begin
      if (mstk.size() > 20) clear_stack();
      for (int i = 0; i < NREG; i++) rf_init[i] = WORD'($urandom);
      load_rf();
      cap = mstk.size() + int'($urandom_range(0, 12));
      if (cap > DEPTH) cap = DEPTH;
      apply_stimulus(bit'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
      finish_op();
    end

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/m_ctx_stacker.md
# m_ctx_stacker

Context save/restore sequencer that drives an `m_stack` LIFO from the initiator side. On a save request it reads NREG registers from the register file and pushes them onto the stack. On a restore request it pops them back and writes them to the register file in the original slots. It sits between the MPU control unit (interrupt entry/exit) and the stack/register file.

## Interface
- `WORD`, 16, data width in bits
- `NREG`, 8, registers per context (2..256); index width `IW = $clog2(NREG)`
- `clk` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-high
- `save_req` in 1: start save; sampled only in IDLE
- `restore_req` in 1: start restore; sampled only in IDLE
- `busy` out 1: high in any state except IDLE
- `done` out 1: one-cycle pulse at end of operation
- `err` out 1: sticky error; cleared at next accepted request
- `stk_push` out 1: push strobe to stack
- `stk_pop` out 1: pop strobe to stack
- `stk_wdata` out WORD: push data
- `stk_rdata` in WORD: stack pop data, registered by the stack
- `stk_full` in 1: stack full
- `stk_empty` in 1: stack empty
- `rf_raddr` out IW: register-file read address; read is combinational
- `rf_rdata` in WORD: register-file read data
- `rf_we` out 1: register-file write enable
- `rf_waddr` out IW: write address
- `rf_wdata` out WORD: write data

## Operation
- Reset values:
  - state IDLE.
  - `busy`, `done`, `err`, `stk_push`, `stk_pop`, `rf_we` all 0.
  - `idx` 0; all address and data outputs 0.
- Reset mid-operation aborts immediately. Already-pushed or popped stack entries are not rolled back.
- IDLE:
  - `save_req` → SAVE, `idx`=0, `err`=0.
  - Otherwise `restore_req` → POP, `idx`=NREG-1, `err`=0.
  - Both high: save wins.
- SAVE, per cycle:
  - `rf_raddr`=`idx`; `stk_wdata`=`rf_rdata`; `stk_push`=!`stk_full`.
  - If `stk_full`: no push, set `err`, → DONE.
  - Else if `idx`==NREG-1 → DONE; else `idx`++.
- POP:
  - If `stk_empty`: set `err`, → DONE.
  - Else `stk_pop`=1, → WB.
- WB:
  - `rf_we`=1, `rf_waddr`=`idx`, `rf_wdata`=`stk_rdata`.
  - If `idx`==0 → DONE; else `idx`--, → POP.
- DONE: `done`=1 for one cycle, → IDLE.
- Requests arriving while `busy` are ignored, not queued.
- `stk_push` and `stk_pop` are never high in the same cycle.
- `rf_we` is high only in WB.

## Timing
- Strobe outputs (`stk_push`, `stk_pop`, `rf_we`) are combinational from state, `idx` and the stack flags. All state is registered.
- Stack contract: pop sampled at edge k; `stk_rdata` is valid after edge k and sampled by WB at edge k+1.
- Save latency:
  - Request edge, then NREG SAVE cycles, then one DONE cycle.
  - `done` high in cycle NREG+1 after acceptance.
- Restore latency: 2·NREG cycles (POP/WB pairs), then DONE.
- Error termination: `done` pulses in the cycle after the failing check; `err` stays high through and after DONE.

## Configuration
- `CTX_CHECKSUM_EN` defined:
  - Save: after the last register, one extra SAVE cycle pushes the XOR of all NREG saved words.
  - Restore: first POP/WB pair loads the checksum into an internal register with no RF write. The NREG register pairs follow, accumulating XOR of the written data.
  - Mismatch at the end sets `err` (writes still performed), then DONE.
  - Latencies become NREG+1 save cycles and 2·(NREG+1) restore cycles.
- Not defined:
  - Exactly NREG stack entries per context.
  - No checksum logic or register is instantiated.

## Test plan
- Reset then RF[i]=0x1000+i, NREG=8, pulse `save_req` → 8 pushes of 0x1000..0x1007 in consecutive cycles; `done` 9 cycles after acceptance; `err`=0.
- Clobber RF to 0, pulse `restore_req` → writes RF[7]=0x1007 down to RF[0]=0x1000; `done` after 16 cycles; RF matches the original.
- Stack with 3 free entries, save → exactly 3 pushes, then `err`=1 and a `done` pulse; next accepted request clears `err`.
- Restore on empty stack → no `rf_we`; `err`=1 and `done` on the next cycle.
- `save_req` and `restore_req` high together in IDLE → save executes. Assert `reset` during the 4th push → all outputs 0 the same cycle, state IDLE.
- With `CTX_CHECKSUM_EN`:
  - Save then restore → 9 pushes, `err`=0.
  - Corrupt the top entry → `err`=1 after the restore.
